mat_store: RTL and testbench
============================

MAT_STORE -- requirements
Module: mat_store

Interface
REQ-001 Parameter MAX_R, default 5, maximum matrix rows accepted.
REQ-002 Parameter MAX_C, default 5, maximum matrix columns accepted.
REQ-003 Parameter SLOTS_PER_DIM, default 8, physical slots per (rows,cols) size class.
REQ-004 Parameter DW, default 8, signed element width.
REQ-005 Ports SHALL be as follows, one per line (name, direction, width, meaning):
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_limit  in  clog2(SLOTS_PER_DIM+1)  logical slots per size class.
- wr_start  in  1  begin a write.
- wr_rows  in  3  write row count, sampled at wr_start.
- wr_cols  in  3  write column count, sampled at wr_start.
- wr_valid  in  1  element beat valid.
- wr_data  in  DW  signed element.
- wr_done  out  1  one-cycle commit pulse.
- wr_slot  out  3  slot committed, valid with wr_done.
- rd_start  in  1  begin a read.
- rd_rows  in  3  read row count.
- rd_cols  in  3  read column count.
- rd_idx  in  3  logical index within the size class.
- rd_valid  out  1  output element valid.
- rd_data  out  DW  output element.
- rd_last  out  1  final element of the matrix.
- busy  out  1  high in any state except IDLE.
- err  out  1  one-cycle error pulse.
- cnt_out  out  4  stored-matrix count for (rd_rows,rd_cols), combinational.

Function
REQ-010 The FSM SHALL have states IDLE, WRITE, COMMIT, READ and no others.
REQ-011 In IDLE, wr_start SHALL move to WRITE if 1<=wr_rows<=MAX_R, 1<=wr_cols<=MAX_C and cfg_limit>=1; otherwise err SHALL pulse the next cycle and the FSM SHALL stay in IDLE.
REQ-012 At wr_start, the target slot SHALL be the head pointer of the size class.
REQ-013 In WRITE, each cycle with wr_valid high SHALL store one element in row-major order; cycles with wr_valid low SHALL stall.
REQ-014 After rows*cols accepted beats, the FSM SHALL enter COMMIT for exactly one cycle.
REQ-015 In COMMIT: wr_done=1 and wr_slot=target; head=(head+1) mod cfg_limit; count=min(count+1,cfg_limit); then return to IDLE.
REQ-016 When wr_start and rd_start are both high in IDLE, the write SHALL win and rd_start SHALL be ignored.
REQ-017 Starts arriving while busy=1 SHALL be ignored and SHALL NOT raise err.
REQ-018 In IDLE, rd_start SHALL enter READ if the dimensions are legal and rd_idx<count; otherwise err SHALL pulse and the FSM SHALL stay in IDLE.
REQ-019 Logical index i SHALL map to physical slot (head-count+i) mod cfg_limit, so index 0 is the oldest matrix.
REQ-020 In READ, the element store SHALL be a synchronous single-port memory.
REQ-021 In READ, the first rd_valid SHALL occur 2 cycles after rd_start, then one element per cycle, row-major, with no gaps.
REQ-022 rd_last SHALL be high with the final rd_valid; the FSM SHALL return to IDLE the cycle after.
REQ-023 cfg_limit SHALL only be sampled in IDLE; a count above a reduced limit SHALL be clamped when the next write to that class commits.
REQ-024 Element arithmetic is not performed; wr_data SHALL be stored and returned bit-exact.

Reset
REQ-030 rst_n low SHALL asynchronously force: IDLE, all counts=0, all heads=0, and wr_done, err, rd_valid, rd_last, busy=0, wr_slot=0, rd_data=0.
REQ-031 Element memory contents need not be cleared.
REQ-032 Reset during WRITE or READ SHALL abandon the operation with no commit.

Configuration
REQ-040 With MAT_STORE_OVERWRITE_EN defined, a write to a full class (count==cfg_limit) SHALL overwrite the oldest slot per REQ-015.
REQ-041 Without MAT_STORE_OVERWRITE_EN, wr_start to a full class SHALL pulse err and stay in IDLE, and no state SHALL change.

Structure
REQ-050 The state enum mat_store_state_t and the SLOTS_PER_DIM default SHALL live in project_pkg; DW SHALL default to DATA_WIDTH and the element type SHALL be matrix_element_t.
REQ-051 The element RAM SHALL be one sub-module, mat_store_ram: depth MAX_R*MAX_C*SLOTS_PER_DIM*MAX_R*MAX_C, 1-cycle read latency.

Verification
REQ-060 Write a 2x3 matrix with 1..6, cfg_limit=2 -> wr_done after 6 beats plus 1 cycle, wr_slot=0, cnt_out=1.
REQ-061 Read 2x3 idx0 -> rd_valid from cycle+2, rd_data 1,2,3,4,5,6, rd_last on 6.
REQ-062 Write three 2x2 matrices A,B,C with limit 2 and overwrite enabled -> idx0=B, idx1=C, count=2; with overwrite disabled -> 3rd wr_start gives err, idx0=A.
REQ-063 wr_start with rows=0 or cols=6; rd_idx=count -> err pulses, busy stays 0.
REQ-064 Simultaneous wr_start and rd_start -> write proceeds, no rd_valid.
REQ-065 rst_n low at beat 3 of a 3x3 write -> count=0, outputs zero; a following read gives err.

Source files
------------

// File: rtl/project_pkg.sv
// -----------------------------------------------------------------------------
// project_pkg
// Shared definitions for the matrix store:
//   - default sizing (element width, slots per size class, max dimensions)
//   - matrix_element_t  : signed element type at the default width
//   - mat_store_state_t : controller states
//   - size_class()      : maps (rows, cols) to a size-class index
//   - mod_pos()         : modulo with a guard for a zero divisor
// -----------------------------------------------------------------------------
package project_pkg;

    localparam int DATA_WIDTH            = 8;
    localparam int SLOTS_PER_DIM_DEFAULT = 8;
    localparam int MAX_R_DEFAULT         = 5;
    localparam int MAX_C_DEFAULT         = 5;

    typedef logic signed [DATA_WIDTH-1:0] matrix_element_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        COMMIT = 2'd2,
        READ   = 2'd3
    } mat_store_state_t;

    // Size classes are laid out row-major over (rows-1, cols-1).
    function automatic int size_class(input int rows, input int cols, input int max_c);
        return (rows - 1) * max_c + (cols - 1);
    endfunction

    // Non-negative dividend assumed; a zero divisor yields 0 instead of X.
    function automatic int mod_pos(input int a, input int m);
        return (m > 0) ? (a % m) : 0;
    endfunction

endpackage

// File: rtl/mat_store_ram.sv
// -----------------------------------------------------------------------------
// mat_store_ram
// Single-port synchronous element memory, one-cycle registered read.
// No reset on the array or the read register so it maps onto block RAM.
//   clk     in   clock
//   i_en    in   port enable (read or write)
//   i_we    in   write enable (qualified by i_en)
//   i_addr  in   word address
//   i_wdata in   write data
//   o_rdata out  read data, valid the cycle after an enabled read
// -----------------------------------------------------------------------------
module mat_store_ram #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_wdata,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                o_rdata <= r_mem[i_addr];
            end
        end
    end

endmodule

// File: rtl/mat_store.sv
// -----------------------------------------------------------------------------
// mat_store
// Stores small signed matrices grouped by size class (rows, cols). Each class
// is a ring of up to cfg_limit slots; logical index 0 is the oldest matrix.
//
// Build option: MAT_STORE_OVERWRITE_EN -- when defined, a write to a full
// class replaces the oldest slot; otherwise such a write is refused with err.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cfg_limit                  logical slots per class (sampled in IDLE)
//   wr_start/wr_rows/wr_cols   begin a write of a rows x cols matrix
//   wr_valid/wr_data           element beats, row-major, stall on !wr_valid
//   wr_done/wr_slot            one-cycle commit pulse and the physical slot
//   rd_start/rd_rows/rd_cols/rd_idx  begin a read of logical index rd_idx
//   rd_valid/rd_data/rd_last   element stream, first element 2 cycles later
//   busy                       high whenever the controller is not IDLE
//   err                        one-cycle pulse for a refused start
//   cnt_out                    stored count for (rd_rows, rd_cols)
// -----------------------------------------------------------------------------
module mat_store
    import project_pkg::*;
#(
    parameter int MAX_R         = MAX_R_DEFAULT,
    parameter int MAX_C         = MAX_C_DEFAULT,
    parameter int SLOTS_PER_DIM = SLOTS_PER_DIM_DEFAULT,
    parameter int DW            = DATA_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [$clog2(SLOTS_PER_DIM+1)-1:0]    cfg_limit,
    input  logic                                  wr_start,
    input  logic [2:0]                            wr_rows,
    input  logic [2:0]                            wr_cols,
    input  logic                                  wr_valid,
    input  logic signed [DW-1:0]                  wr_data,
    output logic                                  wr_done,
    output logic [2:0]                            wr_slot,
    input  logic                                  rd_start,
    input  logic [2:0]                            rd_rows,
    input  logic [2:0]                            rd_cols,
    input  logic [2:0]                            rd_idx,
    output logic                                  rd_valid,
    output logic signed [DW-1:0]                  rd_data,
    output logic                                  rd_last,
    output logic                                  busy,
    output logic                                  err,
    output logic [3:0]                            cnt_out
);

    localparam int LW    = $clog2(SLOTS_PER_DIM + 1);
    localparam int NCLS  = MAX_R * MAX_C;
    localparam int MAXE  = MAX_R * MAX_C;
    localparam int DEPTH = NCLS * SLOTS_PER_DIM * MAXE;
    localparam int AW    = $clog2(DEPTH);
    localparam int CLW   = (NCLS > 1) ? $clog2(NCLS) : 1;
    localparam int EW    = $clog2(MAXE + 1);

    function automatic logic dims_ok(input logic [2:0] r, input logic [2:0] c);
        return (r != 3'd0) && (int'(r) <= MAX_R) && (c != 3'd0) && (int'(c) <= MAX_C);
    endfunction

    // Controller state
    mat_store_state_t r_state;
    logic [LW-1:0]    r_head [NCLS];
    logic [LW-1:0]    r_cnt  [NCLS];
    logic [CLW-1:0]   r_cls;
    logic [LW-1:0]    r_slot;
    logic [LW-1:0]    r_lim;
    logic [AW-1:0]    r_base;
    logic [EW-1:0]    r_idx;      // write beat index, or index of element in RAM output during READ
    logic [EW-1:0]    r_n;
    logic             r_q_vld;    // RAM output holds element r_idx this cycle

    // Decoded start requests
    logic             w_wr_dims_ok;
    logic             w_rd_dims_ok;
    logic [LW-1:0]    w_lim;
    logic [CLW-1:0]   w_wr_cls;
    logic [CLW-1:0]   w_rd_cls;
    logic [LW-1:0]    w_wr_head;
    logic [LW-1:0]    w_wr_cnt;
    logic [LW-1:0]    w_rd_cnt;
    logic             w_wr_block;
    logic             w_wr_ok;
    logic             w_rd_ok;
    logic             w_rd_accept;
    logic [EW-1:0]    w_wr_n;
    logic [EW-1:0]    w_rd_n;
    logic [AW-1:0]    w_wr_base;
    logic [AW-1:0]    w_rd_base;
    int               w_rd_phys;

    // Commit update
    logic [LW-1:0]    w_head_next;
    logic [LW-1:0]    w_cnt_next;

    // RAM port
    logic             w_ram_en;
    logic             w_ram_we;
    logic [AW-1:0]    w_ram_addr;
    logic [DW-1:0]    w_ram_q;
    logic             w_rd_more;

    always_comb begin
        w_wr_dims_ok = dims_ok(wr_rows, wr_cols);
        w_rd_dims_ok = dims_ok(rd_rows, rd_cols);

        // A limit larger than the physical ring is treated as the ring size.
        w_lim = (int'(cfg_limit) > SLOTS_PER_DIM) ? LW'(SLOTS_PER_DIM) : cfg_limit;

        w_wr_cls  = w_wr_dims_ok ? CLW'(size_class(int'(wr_rows), int'(wr_cols), MAX_C)) : '0;
        w_rd_cls  = w_rd_dims_ok ? CLW'(size_class(int'(rd_rows), int'(rd_cols), MAX_C)) : '0;
        w_wr_head = r_head[w_wr_cls];
        w_wr_cnt  = r_cnt[w_wr_cls];
        w_rd_cnt  = r_cnt[w_rd_cls];

`ifdef MAT_STORE_OVERWRITE_EN
        w_wr_block = 1'b0;
`else
        // ">=" also covers a count left above a since-reduced limit.
        w_wr_block = (w_wr_cnt >= w_lim);
`endif

        w_wr_ok     = w_wr_dims_ok && (w_lim != '0) && !w_wr_block;
        w_rd_ok     = w_rd_dims_ok && (w_lim != '0) && (int'(rd_idx) < int'(w_rd_cnt));
        w_rd_accept = rd_start && !wr_start && w_rd_ok;

        w_wr_n    = EW'(int'(wr_rows) * int'(wr_cols));
        w_rd_n    = EW'(int'(rd_rows) * int'(rd_cols));
        w_wr_base = AW'((int'(w_wr_cls) * SLOTS_PER_DIM + int'(w_wr_head)) * MAXE);

        // Oldest entry sits at head-count; lim*count keeps the dividend positive.
        w_rd_phys = mod_pos(int'(r_head[w_rd_cls]) + int'(w_lim) * int'(w_rd_cnt)
                            - int'(w_rd_cnt) + int'(rd_idx), int'(w_lim));
        w_rd_base = AW'((int'(w_rd_cls) * SLOTS_PER_DIM + w_rd_phys) * MAXE);

        w_head_next = LW'(mod_pos(int'(r_head[r_cls]) + 1, int'(r_lim)));
        w_cnt_next  = (r_cnt[r_cls] >= r_lim) ? r_lim : (r_cnt[r_cls] + LW'(1));

        cnt_out = w_rd_dims_ok ? 4'(w_rd_cnt) : 4'd0;
        busy    = (r_state != IDLE);
    end

    // The RAM is fetched one element ahead: the element-0 read is issued on the
    // accepting edge, so the registered output lands two cycles after rd_start.
    always_comb begin
        w_rd_more = r_q_vld && (r_idx != (r_n - EW'(1)));
        w_ram_we  = (r_state == WRITE) && wr_valid;
        w_ram_en  = w_ram_we
                  || ((r_state == IDLE) && w_rd_accept)
                  || ((r_state == READ) && w_rd_more);
        case (r_state)
            WRITE:   w_ram_addr = r_base + AW'(r_idx);
            READ:    w_ram_addr = r_base + AW'(r_idx) + AW'(1);
            default: w_ram_addr = w_rd_base;
        endcase
    end

    mat_store_ram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (wr_data),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cls    <= '0;
            r_slot   <= '0;
            r_lim    <= '0;
            r_base   <= '0;
            r_idx    <= '0;
            r_n      <= '0;
            r_q_vld  <= 1'b0;
            wr_done  <= 1'b0;
            wr_slot  <= 3'd0;
            err      <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            rd_data  <= '0;
            for (int i = 0; i < NCLS; i++) begin
                r_head[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            wr_done <= 1'b0;
            err     <= 1'b0;
            case (r_state)
                IDLE: begin
                    rd_valid <= 1'b0;
                    rd_last  <= 1'b0;
                    if (wr_start) begin
                        if (w_wr_ok) begin
                            r_state <= WRITE;
                            r_cls   <= w_wr_cls;
                            r_slot  <= w_wr_head;
                            r_lim   <= w_lim;
                            r_base  <= w_wr_base;
                            r_idx   <= '0;
                            r_n     <= w_wr_n;
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (rd_start) begin
                        if (w_rd_ok) begin
                            r_state <= READ;
                            r_base  <= w_rd_base;
                            r_n     <= w_rd_n;
                            r_idx   <= '0;
                            r_q_vld <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                WRITE: begin
                    if (wr_valid) begin
                        r_idx <= r_idx + EW'(1);
                        if (r_idx == (r_n - EW'(1))) begin
                            r_state <= COMMIT;
                            wr_done <= 1'b1;
                            wr_slot <= 3'(r_slot);
                        end
                    end
                end

                COMMIT: begin
                    r_head[r_cls] <= w_head_next;
                    r_cnt[r_cls]  <= w_cnt_next;
                    r_state       <= IDLE;
                end

                READ: begin
                    rd_valid <= r_q_vld;
                    rd_last  <= r_q_vld && !w_rd_more;
                    if (r_q_vld) begin
                        rd_data <= w_ram_q;
                    end
                    if (w_rd_more) begin
                        r_idx <= r_idx + EW'(1);
                    end else begin
                        r_q_vld <= 1'b0;
                    end
                    if (rd_last) begin
                        r_state  <= IDLE;
                        rd_valid <= 1'b0;
                        rd_last  <= 1'b0;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mat_store.sv
// -----------------------------------------------------------------------------
// tb_mat_store
// Directed bench for mat_store with hand-computed expectations. Expected
// results for the full-class case follow MAT_STORE_OVERWRITE_EN.
// -----------------------------------------------------------------------------
module tb_mat_store;
    import project_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [3:0]            cfg_limit;
    logic                  wr_start;
    logic [2:0]            wr_rows;
    logic [2:0]            wr_cols;
    logic                  wr_valid;
    matrix_element_t       wr_data;
    logic                  wr_done;
    logic [2:0]            wr_slot;
    logic                  rd_start;
    logic [2:0]            rd_rows;
    logic [2:0]            rd_cols;
    logic [2:0]            rd_idx;
    logic                  rd_valid;
    matrix_element_t       rd_data;
    logic                  rd_last;
    logic                  busy;
    logic                  err;
    logic [3:0]            cnt_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mat_store dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_limit (cfg_limit),
        .wr_start  (wr_start),
        .wr_rows   (wr_rows),
        .wr_cols   (wr_cols),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_done   (wr_done),
        .wr_slot   (wr_slot),
        .rd_start  (rd_start),
        .rd_rows   (rd_rows),
        .rd_cols   (rd_cols),
        .rd_idx    (rd_idx),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .busy      (busy),
        .err       (err),
        .cnt_out   (cnt_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    // Count check for (rows, cols) through the combinational cnt_out.
    task automatic check_cnt(input int rows, input int cols, input int exp, input string tag);
        rd_rows = 3'(rows);
        rd_cols = 3'(cols);
        #1;
        check_eq(tag, 32'(cnt_out), 32'(exp));
    endtask

    // Write rows x cols elements base, base+1, ...; optional one-cycle stall before beat gap_at.
    task automatic do_write(input int rows, input int cols, input int base, input int gap_at,
                            input int exp_slot, input string tag);
        int n;
        int early;
        n     = rows * cols;
        early = 0;
        wr_rows  = 3'(rows);
        wr_cols  = 3'(cols);
        wr_start = 1'b1;
        @(negedge clk);
        wr_start = 1'b0;
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        for (int k = 0; k < n; k++) begin
            if (k == gap_at) begin
                wr_valid = 1'b0;
                @(negedge clk);
                if (wr_done) early++;
            end
            wr_valid = 1'b1;
            wr_data  = 8'(base + k);
            @(negedge clk);
            if ((k < n - 1) && wr_done) early++;
        end
        wr_valid = 1'b0;
        check_eq({tag, "_early_done"}, 32'(early), 32'd0);
        check_eq({tag, "_done"}, 32'(wr_done), 32'd1);
        check_eq({tag, "_slot"}, 32'(wr_slot), 32'(exp_slot));
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, 32'(wr_done), 32'd0);
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Read logical idx of a rows x cols class and expect elements base, base+1, ...
    task automatic rd_check(input int rows, input int cols, input int idx, input int base,
                            input string tag);
        int n;
        int got_n;
        n = rows * cols;
        rd_rows  = 3'(rows);
        rd_cols  = 3'(cols);
        rd_idx   = 3'(idx);
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        check_eq({tag, "_lat1"}, 32'(rd_valid), 32'd0);
        @(negedge clk);
        check_eq({tag, "_lat2"}, 32'(rd_valid), 32'd1);
        got_n = 0;
        for (int c = 0; (c < n + 4) && rd_valid; c++) begin
            check_eq($sformatf("%s_d%0d", tag, got_n), {24'd0, rd_data}, 32'((base + got_n) & 255));
            check_eq($sformatf("%s_last%0d", tag, got_n), 32'(rd_last), 32'(got_n == n - 1));
            got_n++;
            @(negedge clk);
        end
        check_eq({tag, "_count"}, 32'(got_n), 32'(n));
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    // Caller has raised a start that must be refused.
    task automatic expect_err(input string tag);
        @(negedge clk);
        wr_start = 1'b0;
        rd_start = 1'b0;
        check_eq({tag, "_err"}, 32'(err), 32'd1);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        @(negedge clk);
        check_eq({tag, "_err_pulse"}, 32'(err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        cfg_limit = 4'd2;
        wr_start  = 1'b0;
        wr_rows   = 3'd0;
        wr_cols   = 3'd0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_start  = 1'b0;
        rd_rows   = 3'd2;
        rd_cols   = 3'd3;
        rd_idx    = 3'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_wr_done", 32'(wr_done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_rd_valid", 32'(rd_valid), 32'd0);
        check_eq("rst_rd_last", 32'(rd_last), 32'd0);
        check_eq("rst_wr_slot", 32'(wr_slot), 32'd0);
        check_eq("rst_rd_data", {24'd0, rd_data}, 32'd0);
        check_cnt(2, 3, 0, "rst_cnt");

        // 2x3 with 1..6 into an empty class
        do_write(2, 3, 1, -1, 0, "w23");
        check_cnt(2, 3, 1, "w23_cnt");
        rd_check(2, 3, 0, 1, "r23");

        // Three 2x2 matrices with limit 2; A holds negative values, B stalls once
        do_write(2, 2, -8, -1, 0, "wA");
        do_write(2, 2, 20, 2, 1, "wB");
        check_cnt(2, 2, 2, "wAB_cnt");
`ifdef MAT_STORE_OVERWRITE_EN
        do_write(2, 2, 30, -1, 0, "wC");
        check_cnt(2, 2, 2, "wC_cnt");
        rd_check(2, 2, 0, 20, "r22i0");
        rd_check(2, 2, 1, 30, "r22i1");
`else
        wr_rows  = 3'd2;
        wr_cols  = 3'd2;
        wr_start = 1'b1;
        expect_err("wC_full");
        check_cnt(2, 2, 2, "wC_cnt");
        rd_check(2, 2, 0, -8, "r22i0");
        rd_check(2, 2, 1, 20, "r22i1");
`endif

        // Refused starts
        wr_rows = 3'd0; wr_cols = 3'd2; wr_start = 1'b1;
        expect_err("e_rows0");
        wr_rows = 3'd2; wr_cols = 3'd6; wr_start = 1'b1;
        expect_err("e_cols6");
        cfg_limit = 4'd0;
        wr_rows = 3'd1; wr_cols = 3'd1; wr_start = 1'b1;
        expect_err("e_lim0");
        cfg_limit = 4'd2;
        rd_rows = 3'd2; rd_cols = 3'd2; rd_idx = 3'd2; rd_start = 1'b1;
        expect_err("e_idx_cnt");
        rd_rows = 3'd2; rd_cols = 3'd3; rd_idx = 3'd1; rd_start = 1'b1;
        expect_err("e_idx_cnt23");

        // Simultaneous starts: write wins, no read stream
        wr_rows = 3'd1; wr_cols = 3'd1; wr_start = 1'b1;
        rd_rows = 3'd2; rd_cols = 3'd3; rd_idx = 3'd0; rd_start = 1'b1;
        @(negedge clk);
        wr_start = 1'b0;
        rd_start = 1'b0;
        check_eq("sim_busy", 32'(busy), 32'd1);
        check_eq("sim_rdv0", 32'(rd_valid), 32'd0);
        wr_valid = 1'b1;
        wr_data  = 8'd77;
        @(negedge clk);
        wr_valid = 1'b0;
        check_eq("sim_done", 32'(wr_done), 32'd1);
        check_eq("sim_rdv1", 32'(rd_valid), 32'd0);
        @(negedge clk);
        check_eq("sim_rdv2", 32'(rd_valid), 32'd0);
        check_cnt(1, 1, 1, "sim_cnt");
        rd_check(1, 1, 0, 77, "r11");

        // 3x3 write: starts while busy are ignored, then reset on the third beat
        wr_rows = 3'd3; wr_cols = 3'd3; wr_start = 1'b1;
        @(negedge clk);
        wr_start = 1'b1;
        wr_rows  = 3'd0;
        wr_valid = 1'b1;
        wr_data  = 8'd1;
        @(negedge clk);
        wr_start = 1'b0;
        check_eq("busy_wr_err", 32'(err), 32'd0);
        rd_start = 1'b1;
        rd_rows  = 3'd3; rd_cols = 3'd3; rd_idx = 3'd7;
        wr_data  = 8'd2;
        @(negedge clk);
        rd_start = 1'b0;
        check_eq("busy_rd_err", 32'(err), 32'd0);
        check_eq("busy_still", 32'(busy), 32'd1);
        wr_data = 8'd3;
        rst_n   = 1'b0;
        #1;
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_wr_done", 32'(wr_done), 32'd0);
        check_eq("arst_rd_data", {24'd0, rd_data}, 32'd0);
        check_eq("arst_wr_slot", 32'(wr_slot), 32'd0);
        check_cnt(3, 3, 0, "arst_cnt33");
        check_cnt(2, 3, 0, "arst_cnt23");
        check_cnt(1, 1, 0, "arst_cnt11");
        @(negedge clk);
        wr_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        check_eq("post_rst_done", 32'(wr_done), 32'd0);
        rd_rows = 3'd3; rd_cols = 3'd3; rd_idx = 3'd0; rd_start = 1'b1;
        expect_err("post_rst_rd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
